// File: rtl/can_pkg.sv
// rtl/can_pkg.sv - shared types for the CAN TX mailbox scheduler
package can_pkg;

    localparam int KEY_W = 30;

    typedef logic [KEY_W-1:0] arb_key_t;

    typedef struct packed {
        logic [28:0] id;
        logic        ide;
        logic [3:0]  dlc;
        logic [63:0] data;
    } mbox_t;

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        REQ,
        CANCEL
    } state_t;

    // Lower key wins arbitration; a standard frame beats an extended one with the same base.
    function automatic arb_key_t build_key(input logic [28:0] id, input logic ide);
        if (ide) begin
            return {id[28:18], 1'b1, id[17:0]};
        end
        return {id[10:0], 1'b0, 18'h0};
    endfunction

endpackage

// File: rtl/can_prio_sel.sv
// rtl/can_prio_sel.sv - combinational minimum-key finder over the pending mailboxes
module can_prio_sel
    import can_pkg::*;
#(
    parameter int MBOX  = 8,
    parameter int IDX_W = $clog2(MBOX)
) (
    input  logic [MBOX-1:0]       pend,
    input  logic [MBOX*KEY_W-1:0] keys,
    output logic [IDX_W-1:0]      win_idx,
    output logic                  win_vld
);

    arb_key_t best_key;

    // Strict less-than keeps the earlier (lower) index on equal keys.
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = '0;
        best_key = '1;
        for (int i = 0; i < MBOX; i++) begin
            if (pend[i] && (!win_vld || keys[i*KEY_W +: KEY_W] < best_key)) begin
                win_vld  = 1'b1;
                win_idx  = IDX_W'(i);
                best_key = keys[i*KEY_W +: KEY_W];
            end
        end
    end

endmodule

// File: rtl/can_tx_sched.sv
// rtl/can_tx_sched.sv - per-channel CAN TX mailbox scheduler
module can_tx_sched
    import can_pkg::*;
#(
    parameter int MBOX      = 8,
    parameter int IDX_W     = $clog2(MBOX),
    parameter int MAX_RETRY = 0
) (
    input  logic             clk_can,
    input  logic             rst_can,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [28:0]      wr_id,
    input  logic             wr_ide,
    input  logic [3:0]       wr_dlc,
    input  logic [63:0]      wr_data,
    output logic             wr_rej,
    input  logic [MBOX-1:0]  abort_req,
    output logic [31:0]      tx_id,
    output logic [3:0]       tx_dlc,
    output logic [63:0]      tx_data,
    output logic             tx_req,
    output logic             tx_cancel,
    input  logic             tx_done,
    input  logic             tx_cancel_ack,
    input  logic             tx_arb_lost,
    input  logic             tx_error,
    input  logic             bus_off,
    output logic [MBOX-1:0]  mb_pending,
    output logic [MBOX-1:0]  mb_done,
    output logic [MBOX-1:0]  mb_abort,
    output logic [MBOX-1:0]  mb_fail,
    output logic             busy
);

    mbox_t              ent_q [MBOX];
    mbox_t              ent_d [MBOX];
    logic [MBOX-1:0]    pend_q, pend_d;
    logic [MBOX-1:0]    done_q, done_d;
    logic [MBOX-1:0]    abort_q, abort_d;
    logic [MBOX-1:0]    fail_q, fail_d;
    logic               wr_rej_q, wr_rej_d;
    state_t             state_q, state_d;
    logic [IDX_W-1:0]   act_q, act_d;
    logic [15:0]        retry_q, retry_d;

    logic [MBOX*KEY_W-1:0] keys;
    logic [MBOX-1:0]       sel_mask;
    logic [IDX_W-1:0]      win_idx;
    logic                  win_vld;
    logic                  in_flight;
    logic [15:0]           retry_inc;
    mbox_t                 act_ent;

    always_comb begin
        keys = '0;
        for (int i = 0; i < MBOX; i++) begin
            keys[i*KEY_W +: KEY_W] = build_key(ent_q[i].id, ent_q[i].ide);
        end
    end

    // A mailbox being aborted this cycle must not win the selection it is leaving.
    assign sel_mask = pend_q & ~abort_req;

    can_prio_sel #(.MBOX(MBOX), .IDX_W(IDX_W)) u_prio_sel (
        .pend    (sel_mask),
        .keys    (keys),
        .win_idx (win_idx),
        .win_vld (win_vld)
    );

    assign in_flight = (state_q == REQ) || (state_q == CANCEL);
    assign retry_inc = retry_q + 16'd1;
    assign act_ent   = ent_q[act_q];

    always_comb begin
        ent_d    = ent_q;
        pend_d   = pend_q;
        done_d   = '0;
        abort_d  = '0;
        fail_d   = '0;
        wr_rej_d = 1'b0;
        state_d  = state_q;
        act_d    = act_q;
        retry_d  = retry_q;

        for (int i = 0; i < MBOX; i++) begin
            if (abort_req[i] && pend_q[i] && !(in_flight && act_q == IDX_W'(i))) begin
                pend_d[i]  = 1'b0;
                abort_d[i] = 1'b1;
            end
        end

        if (wr_en) begin
            if (in_flight && wr_idx == act_q) begin
                wr_rej_d = 1'b1;
            end else begin
                ent_d[wr_idx]   = '{id: wr_id, ide: wr_ide, dlc: wr_dlc, data: wr_data};
                pend_d[wr_idx]  = 1'b1;
                abort_d[wr_idx] = 1'b0;
            end
        end

        case (state_q)
            IDLE: begin
                if (|pend_q && !bus_off) begin
                    state_d = SELECT;
                end
            end
            SELECT: begin
                if (win_vld) begin
                    act_d = win_idx;
                    if (win_idx != act_q) begin
                        retry_d = '0;
                    end
                    state_d = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (tx_done) begin
                    done_d[act_q] = 1'b1;
                    pend_d[act_q] = 1'b0;
                    state_d       = IDLE;
                end else if (tx_arb_lost || tx_error) begin
                    if (MAX_RETRY != 0 && retry_inc >= 16'(MAX_RETRY)) begin
                        fail_d[act_q] = 1'b1;
                        pend_d[act_q] = 1'b0;
                        retry_d       = '0;
                    end else begin
                        retry_d = retry_inc;
                    end
                    state_d = IDLE;
                end else if (abort_req[act_q]) begin
                    state_d = CANCEL;
                end else if (bus_off) begin
                    state_d = IDLE;
                end
            end
            CANCEL: begin
                if (tx_done) begin
                    done_d[act_q] = 1'b1;
                    pend_d[act_q] = 1'b0;
                    state_d       = IDLE;
                end else if (tx_cancel_ack || tx_arb_lost || tx_error) begin
                    abort_d[act_q] = 1'b1;
                    pend_d[act_q]  = 1'b0;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_can) begin
        if (rst_can) begin
            for (int i = 0; i < MBOX; i++) begin
                ent_q[i] <= '0;
            end
            pend_q   <= '0;
            done_q   <= '0;
            abort_q  <= '0;
            fail_q   <= '0;
            wr_rej_q <= 1'b0;
            state_q  <= IDLE;
            act_q    <= '0;
            retry_q  <= '0;
        end else begin
            ent_q    <= ent_d;
            pend_q   <= pend_d;
            done_q   <= done_d;
            abort_q  <= abort_d;
            fail_q   <= fail_d;
            wr_rej_q <= wr_rej_d;
            state_q  <= state_d;
            act_q    <= act_d;
            retry_q  <= retry_d;
        end
    end

    assign tx_req     = in_flight;
    assign tx_cancel  = (state_q == CANCEL);
    assign tx_id      = in_flight ? {act_ent.ide, 2'b00, act_ent.id} : '0;
    assign tx_dlc     = in_flight ? act_ent.dlc : '0;
    assign tx_data    = in_flight ? act_ent.data : '0;
    assign wr_rej     = wr_rej_q;
    assign mb_pending = pend_q;
    assign mb_done    = done_q;
    assign mb_abort   = abort_q;
    assign mb_fail    = fail_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_can_tx_sched.sv
// tb/tb_can_tx_sched.sv - self-checking bench for can_tx_sched
module tb_can_tx_sched;

    localparam int MBOX      = 8;
    localparam int IDX_W     = 3;
    localparam int MAX_RETRY = 2;

    logic              clk_can;
    logic              rst_can;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [28:0]       wr_id;
    logic              wr_ide;
    logic [3:0]        wr_dlc;
    logic [63:0]       wr_data;
    logic              wr_rej;
    logic [MBOX-1:0]   abort_req;
    logic [31:0]       tx_id;
    logic [3:0]        tx_dlc;
    logic [63:0]       tx_data;
    logic              tx_req;
    logic              tx_cancel;
    logic              tx_done;
    logic              tx_cancel_ack;
    logic              tx_arb_lost;
    logic              tx_error;
    logic              bus_off;
    logic [MBOX-1:0]   mb_pending;
    logic [MBOX-1:0]   mb_done;
    logic [MBOX-1:0]   mb_abort;
    logic [MBOX-1:0]   mb_fail;
    logic              busy;

    can_tx_sched #(.MBOX(MBOX), .IDX_W(IDX_W), .MAX_RETRY(MAX_RETRY)) dut (
        .clk_can       (clk_can),
        .rst_can       (rst_can),
        .wr_en         (wr_en),
        .wr_idx        (wr_idx),
        .wr_id         (wr_id),
        .wr_ide        (wr_ide),
        .wr_dlc        (wr_dlc),
        .wr_data       (wr_data),
        .wr_rej        (wr_rej),
        .abort_req     (abort_req),
        .tx_id         (tx_id),
        .tx_dlc        (tx_dlc),
        .tx_data       (tx_data),
        .tx_req        (tx_req),
        .tx_cancel     (tx_cancel),
        .tx_done       (tx_done),
        .tx_cancel_ack (tx_cancel_ack),
        .tx_arb_lost   (tx_arb_lost),
        .tx_error      (tx_error),
        .bus_off       (bus_off),
        .mb_pending    (mb_pending),
        .mb_done       (mb_done),
        .mb_abort      (mb_abort),
        .mb_fail       (mb_fail),
        .busy          (busy)
    );

    initial begin
        clk_can = 1'b0;
        forever #5 clk_can = ~clk_can;
    end

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: mailbox contents, pending set, in-flight index and retry bookkeeping.
    logic [28:0] m_id   [MBOX];
    logic        m_ide  [MBOX];
    logic [3:0]  m_dlc  [MBOX];
    logic [63:0] m_data [MBOX];
    logic [7:0]  m_pend;
    int          m_inflight;
    int          m_retry;
    int          m_last;

    function automatic longint prio(input int i);
        if (m_ide[i]) begin
            return longint'(m_id[i][28:18]) * 524288 + 262144 + longint'(m_id[i][17:0]);
        end
        return longint'(m_id[i][10:0]) * 524288;
    endfunction

    function automatic int best();
        int b;
        b = -1;
        for (int i = 0; i < MBOX; i++) begin
            if (m_pend[i] && (b < 0 || prio(i) < prio(b))) b = i;
        end
        return b;
    endfunction

    function automatic logic [31:0] exp_id(input int i);
        return {m_ide[i], 2'b00, m_id[i]};
    endfunction

    task automatic tick();
        @(posedge clk_can);
        #1;
    endtask

    task automatic model_clear();
        m_pend     = '0;
        m_inflight = -1;
        m_retry    = 0;
        m_last     = -1;
    endtask

    task automatic load(input int idx, input logic [28:0] id, input logic ide,
                        input logic [3:0] dlc, input logic [63:0] data);
        wr_en   = 1'b1;
        wr_idx  = 3'(idx);
        wr_id   = id;
        wr_ide  = ide;
        wr_dlc  = dlc;
        wr_data = data;
        tick();
        wr_en = 1'b0;
        if (idx != m_inflight) begin
            m_id[idx]   = id;
            m_ide[idx]  = ide;
            m_dlc[idx]  = dlc;
            m_data[idx] = data;
            m_pend[idx] = 1'b1;
        end
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (tx_req !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
    endtask

    task automatic start_frame(output int idx, output int n);
        wait_req(n);
        idx = -1;
        vectors++;
        if (tx_req !== 1'b1) begin
            miscompares++;
            $display("FAIL req_timeout tx_req=%b want 1 after %0d cycles", tx_req, n);
            return;
        end
        idx = best();
        if (idx < 0) begin
            miscompares++;
            $display("FAIL spurious_req tx_req=1 want 0 (model has nothing pending)");
            return;
        end
        if (idx != m_last) m_retry = 0;
        m_last     = idx;
        m_inflight = idx;
        vectors++;
        if ({tx_id, tx_dlc, tx_data} !== {exp_id(idx), m_dlc[idx], m_data[idx]}) begin
            miscompares++;
            $display("FAIL frame got id=%h dlc=%h data=%h want id=%h dlc=%h data=%h (mb%0d)",
                     tx_id, tx_dlc, tx_data, exp_id(idx), m_dlc[idx], m_data[idx], idx);
        end
    endtask

    // kind 0 = transmitted, 1 = arbitration lost or error
    task automatic finish_frame(input int kind);
        int idx;
        logic [7:0] e_done;
        logic [7:0] e_fail;
        idx    = m_inflight;
        e_done = '0;
        e_fail = '0;
        if (idx < 0) return;
        if (kind == 0) tx_done = 1'b1;
        else if ($urandom_range(1) == 1) tx_error = 1'b1;
        else tx_arb_lost = 1'b1;
        tick();
        tx_done     = 1'b0;
        tx_error    = 1'b0;
        tx_arb_lost = 1'b0;
        if (kind == 0) begin
            e_done[idx] = 1'b1;
            m_pend[idx] = 1'b0;
        end else begin
            m_retry++;
            if (m_retry >= MAX_RETRY) begin
                e_fail[idx] = 1'b1;
                m_pend[idx] = 1'b0;
                m_retry     = 0;
            end
        end
        m_inflight = -1;
        vectors++;
        if ({mb_done, mb_fail, mb_abort} !== {e_done, e_fail, 8'h00}) begin
            miscompares++;
            $display("FAIL completion got done=%b fail=%b abort=%b want done=%b fail=%b abort=0",
                     mb_done, mb_fail, mb_abort, e_done, e_fail);
        end
        vectors++;
        if (mb_pending !== m_pend || tx_req !== 1'b0) begin
            miscompares++;
            $display("FAIL after_completion got pending=%b tx_req=%b want pending=%b tx_req=0",
                     mb_pending, tx_req, m_pend);
        end
    endtask

    task automatic drain();
        int idx;
        int n;
        int guard;
        guard = 0;
        while (m_pend != 0 && guard < 40) begin
            start_frame(idx, n);
            if (idx < 0) break;
            finish_frame(($urandom_range(3) == 0) ? 1 : 0);
            guard++;
        end
    endtask

    task automatic test_reset();
        rst_can = 1'b1;
        tick();
        tick();
        rst_can = 1'b0;
        model_clear();
        vectors++;
        if ({tx_req, tx_cancel, busy, wr_rej} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_ctrl got req/cancel/busy/rej=%b want 0000",
                     {tx_req, tx_cancel, busy, wr_rej});
        end
        vectors++;
        if ({mb_pending, mb_done, mb_abort, mb_fail} !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mbox got pend=%b done=%b abort=%b fail=%b want all 0",
                     mb_pending, mb_done, mb_abort, mb_fail);
        end
        vectors++;
        if ({tx_id, tx_dlc, tx_data} !== 100'h0) begin
            miscompares++;
            $display("FAIL reset_frame got id=%h dlc=%h data=%h want 0", tx_id, tx_dlc, tx_data);
        end
    endtask

    task automatic test_order();
        int idx;
        int n;
        logic [31:0] ord_tx [3];
        logic [7:0]  ord_done [3];
        ord_tx   = '{32'h8246_8ACE, 32'h0000_0123, 32'h0000_0123};
        ord_done = '{8'h20, 8'h02, 8'h08};
        bus_off = 1'b1;
        load(3, 29'h123, 1'b0, 4'($urandom), {$urandom, $urandom});
        load(1, 29'h123, 1'b0, 4'($urandom), {$urandom, $urandom});
        load(5, 29'h0246_8ACE, 1'b1, 4'($urandom), {$urandom, $urandom});
        bus_off = 1'b0;
        for (int k = 0; k < 3; k++) begin
            start_frame(idx, n);
            if (idx < 0) return;
            vectors++;
            if (tx_id !== ord_tx[k]) begin
                miscompares++;
                $display("FAIL order_id[%0d] got %h want %h", k, tx_id, ord_tx[k]);
            end
            if (k > 0) begin
                vectors++;
                if (n != 2) begin
                    miscompares++;
                    $display("FAIL order_gap[%0d] got %0d idle cycles want 2", k, n);
                end
            end
            finish_frame(0);
            vectors++;
            if (mb_done !== ord_done[k]) begin
                miscompares++;
                $display("FAIL order_done[%0d] got %b want %b", k, mb_done, ord_done[k]);
            end
        end
    endtask

    task automatic test_retry();
        int idx;
        int n;
        load(2, 29'($urandom_range(0, 2047)), 1'b0, 4'($urandom), {$urandom, $urandom});
        start_frame(idx, n);
        if (idx < 0) return;
        vectors++;
        if (n != 2) begin
            miscompares++;
            $display("FAIL load_latency got %0d cycles after load tick want 2", n);
        end
        finish_frame(1);
        start_frame(idx, n);
        if (idx < 0) return;
        finish_frame(1);
        vectors++;
        if (mb_fail !== 8'h04 || mb_pending[2] !== 1'b0) begin
            miscompares++;
            $display("FAIL retry_limit got fail=%b pend2=%b want fail=00000100 pend2=0",
                     mb_fail, mb_pending[2]);
        end
    endtask

    task automatic test_abort();
        int idx;
        int n;
        for (int r = 0; r < 2; r++) begin
            load(4, 29'($urandom), 1'b1, 4'($urandom), {$urandom, $urandom});
            start_frame(idx, n);
            if (idx < 0) return;
            abort_req = 8'h10;
            tick();
            abort_req = 8'h00;
            vectors++;
            if ({tx_req, tx_cancel} !== 2'b11) begin
                miscompares++;
                $display("FAIL cancel_req[%0d] got req=%b cancel=%b want 1 1", r, tx_req, tx_cancel);
            end
            if (r == 0) tx_cancel_ack = 1'b1;
            else tx_done = 1'b1;
            tick();
            tx_cancel_ack = 1'b0;
            tx_done       = 1'b0;
            m_pend[4]  = 1'b0;
            m_inflight = -1;
            vectors++;
            if ({mb_abort, mb_done} !== ((r == 0) ? 16'h1000 : 16'h0010)) begin
                miscompares++;
                $display("FAIL cancel_result[%0d] got abort=%b done=%b", r, mb_abort, mb_done);
            end
            vectors++;
            if (mb_pending !== m_pend || tx_cancel !== 1'b0) begin
                miscompares++;
                $display("FAIL cancel_pend[%0d] got pend=%b cancel=%b want pend=%b cancel=0",
                         r, mb_pending, tx_cancel, m_pend);
            end
        end
        bus_off = 1'b1;
        load(6, 29'($urandom), 1'b0, 4'($urandom), {$urandom, $urandom});
        abort_req = 8'h40;
        tick();
        abort_req = 8'h00;
        m_pend[6] = 1'b0;
        vectors++;
        if (mb_abort !== 8'h40 || mb_pending !== m_pend) begin
            miscompares++;
            $display("FAIL idle_abort got abort=%b pend=%b want abort=01000000 pend=%b",
                     mb_abort, mb_pending, m_pend);
        end
        abort_req = 8'h01;
        tick();
        abort_req = 8'h00;
        vectors++;
        if (mb_abort !== 8'h00) begin
            miscompares++;
            $display("FAIL abort_nonpending got abort=%b want 0", mb_abort);
        end
        bus_off = 1'b0;
    endtask

    task automatic test_load_rej();
        int idx;
        int n;
        bus_off = 1'b1;
        load(0, 29'h010, 1'b0, 4'h3, {$urandom, $urandom});
        load(7, 29'h700, 1'b0, 4'h5, {$urandom, $urandom});
        bus_off = 1'b0;
        start_frame(idx, n);
        if (idx < 0) return;
        load(0, 29'($urandom), 1'b1, 4'($urandom), {$urandom, $urandom});
        vectors++;
        if (wr_rej !== 1'b1 || tx_data !== m_data[0]) begin
            miscompares++;
            $display("FAIL wr_rej got rej=%b data=%h want rej=1 data=%h", wr_rej, tx_data, m_data[0]);
        end
        load(7, 29'h700, 1'b0, 4'h8, 64'h0000_0000_DEAD_BEEF);
        vectors++;
        if (wr_rej !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_accept got rej=%b want 0", wr_rej);
        end
        finish_frame(0);
        start_frame(idx, n);
        if (idx < 0) return;
        vectors++;
        if (tx_data !== 64'h0000_0000_DEAD_BEEF) begin
            miscompares++;
            $display("FAIL overwrite_data got %h want 00000000deadbeef", tx_data);
        end
        finish_frame(0);
    endtask

    task automatic test_bus_off();
        int idx;
        int n;
        int slots [3];
        slots = '{1, 2, 6};
        bus_off = 1'b1;
        foreach (slots[k]) begin
            load(slots[k], 29'($urandom), 1'($urandom), 4'($urandom), {$urandom, $urandom});
        end
        bus_off = 1'b0;
        start_frame(idx, n);
        if (idx < 0) return;
        bus_off = 1'b1;
        tick();
        m_inflight = -1;
        vectors++;
        if (tx_req !== 1'b0 || mb_pending !== m_pend || (mb_done | mb_abort | mb_fail) !== 8'h00) begin
            miscompares++;
            $display("FAIL bus_off_drop got req=%b pend=%b pulses=%b want req=0 pend=%b pulses=0",
                     tx_req, mb_pending, mb_done | mb_abort | mb_fail, m_pend);
        end
        repeat (4) tick();
        vectors++;
        if (tx_req !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL bus_off_hold got req=%b busy=%b want 0 0", tx_req, busy);
        end
        bus_off = 1'b0;
        drain();
    endtask

    task automatic test_random();
        logic        ide;
        logic [28:0] id;
        for (int r = 0; r < 8; r++) begin
            bus_off = 1'b1;
            repeat ($urandom_range(1, 5)) begin
                ide = 1'($urandom);
                if (ide) id = {11'($urandom_range(0, 3)), 18'($urandom_range(0, 1))};
                else     id = 29'($urandom_range(0, 3) << 18 >> 18) | 29'($urandom_range(0, 3));
                load($urandom_range(0, MBOX - 1), id, ide, 4'($urandom), {$urandom, $urandom});
            end
            bus_off = 1'b0;
            drain();
        end
    endtask

    task automatic test_reset_cancel();
        int idx;
        int n;
        load(3, 29'($urandom), 1'b0, 4'($urandom), {$urandom, $urandom});
        start_frame(idx, n);
        if (idx < 0) return;
        abort_req = 8'h08;
        tick();
        vectors++;
        if (tx_cancel !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_cancel got cancel=%b want 1", tx_cancel);
        end
        rst_can   = 1'b1;
        abort_req = 8'h00;
        tick();
        rst_can = 1'b0;
        model_clear();
        vectors++;
        if ({tx_req, tx_cancel, busy, wr_rej, mb_done, mb_abort, mb_fail, mb_pending} !== 36'h0 ||
            {tx_id, tx_dlc, tx_data} !== 100'h0) begin
            miscompares++;
            $display("FAIL reset_mid_cancel got req=%b cancel=%b busy=%b pend=%b id=%h want all 0",
                     tx_req, tx_cancel, busy, mb_pending, tx_id);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_can       = 1'b1;
        wr_en         = 1'b0;
        wr_idx        = '0;
        wr_id         = '0;
        wr_ide        = 1'b0;
        wr_dlc        = '0;
        wr_data       = '0;
        abort_req     = '0;
        tx_done       = 1'b0;
        tx_cancel_ack = 1'b0;
        tx_arb_lost   = 1'b0;
        tx_error      = 1'b0;
        bus_off       = 1'b0;
        model_clear();
        test_reset();
        test_order();
        test_retry();
        test_abort();
        test_load_rej();
        test_bus_off();
        test_random();
        test_reset_cancel();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/can_tx_sched.md
Name: can_tx_sched

Overview:
- Per-channel TX mailbox scheduler for the CAN controller.
- Holds MBOX transmit mailboxes loaded over a simple write port.
- Presents the highest-priority pending frame, by CAN arbitration order, on the controller's tx_req/tx_done/tx_cancel handshake.
- Handles retry after lost arbitration or error, abort, and bus-off hold. One instance per CAN channel, on the CAN clock.

Parameters:
- MBOX, 8, number of TX mailboxes (2..32).
- IDX_W, $clog2(MBOX), mailbox index width.
- MAX_RETRY, 0, attempts per frame before failing it. 0 means unlimited.

Ports:
- clk_can  in  1  CAN core clock; only clock.
- rst_can  in  1  Reset, synchronous, active-high.
- wr_en  in  1  Mailbox load strobe.
- wr_idx  in  IDX_W  Target mailbox.
- wr_id  in  29  Identifier; standard IDs in [10:0].
- wr_ide  in  1  1 = extended frame.
- wr_dlc  in  4  Data length code.
- wr_data  in  64  Payload.
- wr_rej  out  1  One-cycle pulse: load rejected because the target mailbox is in flight.
- abort_req  in  MBOX  Per-mailbox abort; level sampled each cycle.
- tx_id  out  32  {wr_ide, 2'b00, id[28:0]} of the in-flight frame.
- tx_dlc  out  4  DLC of the in-flight frame.
- tx_data  out  64  Payload of the in-flight frame.
- tx_req  out  1  Frame request to the controller.
- tx_cancel  out  1  Cancel request for the in-flight frame.
- tx_done  in  1  Pulse: frame transmitted and acknowledged.
- tx_cancel_ack  in  1  Pulse: cancel honoured, frame not sent.
- tx_arb_lost  in  1  Pulse: arbitration lost.
- tx_error  in  1  Pulse: transmit error.
- bus_off  in  1  Controller is in bus-off (level).
- mb_pending  out  MBOX  Mailbox valid and not yet completed.
- mb_done  out  MBOX  One-cycle success pulse.
- mb_abort  out  MBOX  One-cycle aborted pulse.
- mb_fail  out  MBOX  One-cycle pulse: retry limit exhausted.
- busy  out  1  FSM not in IDLE.

Behaviour:
- **Reset:** all outputs are 0, all mailboxes invalid, retry count 0, FSM in IDLE. Reset applies mid-transfer with no cancel handshake.
- **Arbitration key (30 bits, lower wins):**
  - Extended: {id[28:18], 1'b1, id[17:0]}.
  - Standard: {id[10:0], 1'b0, 18'h0}.
  - Equal keys: the lower mailbox index wins.
- **Load:** a load sets entry and pending in the next cycle.
  - Loading the in-flight mailbox is dropped and wr_rej pulses.
  - Loading a pending, not-in-flight mailbox overwrites it and keeps it pending.
- **Abort of a non-in-flight pending mailbox:** pending clears next cycle and mb_abort pulses once. Abort of a non-pending mailbox is ignored.
- **FSM states:**
  - IDLE: if any mailbox is pending and bus_off=0, go to SELECT.
  - SELECT: register the winner index from this cycle's pending set, reset the retry count if the index changed, go to REQ.
  - REQ: hold tx_req=1 with tx_id/tx_dlc/tx_data stable.
    - tx_done: set mb_done, clear pending, go to IDLE.
    - tx_arb_lost or tx_error: increment retry, go to IDLE; the mailbox stays pending, so the winner is re-evaluated.
    - abort_req[active]=1: go to CANCEL.
  - CANCEL: hold tx_req=1 and tx_cancel=1.
    - tx_done: mb_done (done wins).
    - tx_cancel_ack, tx_arb_lost or tx_error: mb_abort, clear pending.
    - Then go to IDLE.
- **Latency:** tx_req rises 3 cycles after wr_en into an idle scheduler (load, SELECT, REQ).
- **Retry limit:** if MAX_RETRY≠0 and the retry count reaches MAX_RETRY after a failure, mb_fail pulses, pending clears, and the count resets.
- **Bus-off:** while bus_off=1 in REQ, drop tx_req and return to IDLE without a completion pulse. Pending mailboxes are kept; no new SELECT occurs until bus_off=0.
- **Simultaneous events in REQ:** tx_done has priority over abort_req and arb_lost. A new higher-priority load does not preempt the in-flight frame.
- **Output timing:** completion pulses occur the cycle after the controller pulse.
- **Stray pulses:** controller pulses received in IDLE or SELECT are ignored.

Decomposition:
- can_pkg holds:
  - the 30-bit arbitration-key typedef and build function;
  - the mailbox entry struct {id, ide, dlc, data};
  - the FSM state enum {IDLE, SELECT, REQ, CANCEL}.
- Sub-module can_prio_sel: purely combinational MBOX-way minimum-key finder. Inputs are the pending mask and keys; outputs are the winner index and valid. Ties resolve to the lower index.

Test Plan:
- Load mb3 std 0x123, then mb1 std 0x123, then mb5 ext 0x0246_8ACE (base 0x091) while idle → order mb5, mb1, mb3. Each tx_req follows tx_done plus 2 cycles; mb_done bits pulse in that order.
- mb2 in REQ, one tx_arb_lost pulse, MAX_RETRY=2 → tx_req re-asserts with the same tx_id. A second tx_arb_lost → mb_fail[2] pulses and mb_pending[2]=0.
- abort_req[4] while mb4 is in REQ → tx_cancel=1. tx_cancel_ack → mb_abort[4] pulses, no mb_done. Repeat with tx_done instead of ack → mb_done[4] only.
- wr_en to the in-flight mailbox → wr_rej pulses and tx_data is unchanged. wr_en to a pending idle mailbox with data 0xDEAD_BEEF → that data is sent.
- bus_off=1 during REQ with 3 mailboxes pending → tx_req drops within 1 cycle and mb_pending is unchanged. After bus_off=0, transmission resumes from the best key.
- rst_can asserted mid-CANCEL → next cycle all outputs 0 and mb_pending=0.
